// File: rtl/ctrl_pkg.sv
// Shared encodings for the datapath controller: FSM states, opcodes, ALU codes,
// branch conditions, mux selects and the EXEC-stage instruction decoder.
package ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ALU_W  = 4;
    localparam int unsigned PSR_W  = 5;
    localparam int unsigned OP_W   = 4;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_EXEC     = 3'd2,
        S_LOAD_MEM = 3'd3,
        S_LOAD_WB  = 3'd4,
        S_STOR     = 3'd5,
        S_BRANCH   = 3'd6
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_CMP = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0011;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0100;
    localparam logic [ALU_W-1:0] ALU_XOR = 4'b0101;
    localparam logic [ALU_W-1:0] ALU_MOV = 4'b0110;

    // R-type OpCodeExt values equal the matching I-type OpCodes.
    localparam logic [OP_W-1:0] OP_RTYPE = 4'b0000;
    localparam logic [OP_W-1:0] OP_ANDI  = 4'b0001;
    localparam logic [OP_W-1:0] OP_ORI   = 4'b0010;
    localparam logic [OP_W-1:0] OP_XORI  = 4'b0011;
    localparam logic [OP_W-1:0] OP_MEM   = 4'b0100;
    localparam logic [OP_W-1:0] OP_ADDI  = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHIFT = 4'b1000;
    localparam logic [OP_W-1:0] OP_SUBI  = 4'b1001;
    localparam logic [OP_W-1:0] OP_CMPI  = 4'b1011;
    localparam logic [OP_W-1:0] OP_BCOND = 4'b1100;
    localparam logic [OP_W-1:0] OP_MOVI  = 4'b1101;

    localparam logic [OP_W-1:0] EXT_LOAD = 4'b0000;
    localparam logic [OP_W-1:0] EXT_STOR = 4'b0100;
    localparam logic [OP_W-1:0] EXT_LSH  = 4'b0100;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_HI = 4'h4;
    localparam logic [3:0] COND_LS = 4'h5;
    localparam logic [3:0] COND_GT = 4'h6;
    localparam logic [3:0] COND_LE = 4'h7;
    localparam logic [3:0] COND_FS = 4'h8;
    localparam logic [3:0] COND_FC = 4'h9;
    localparam logic [3:0] COND_LO = 4'hA;
    localparam logic [3:0] COND_HS = 4'hB;
    localparam logic [3:0] COND_LT = 4'hC;
    localparam logic [3:0] COND_GE = 4'hD;
    localparam logic [3:0] COND_UC = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam logic [1:0] MUX4_REG = 2'b00;
    localparam logic [1:0] MUX4_IMM = 2'b01;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_MOV   = 2'b10;

    typedef struct packed {
        logic             valid;
        logic             wb;
        logic             imm;
        logic             set_psr;
        logic             mov;
        logic             zext;
        logic             shift;
        logic             shift_imm;
        logic [ALU_W-1:0] alu;
    } exec_dec_t;

    function automatic exec_dec_t alu_op(input logic [OP_W-1:0] code);
        exec_dec_t d;
        d       = '0;
        d.valid = 1'b1;
        d.wb    = 1'b1;
        case (code)
            OP_ADDI: begin d.alu = ALU_ADD; d.set_psr = 1'b1; end
            OP_SUBI: begin d.alu = ALU_SUB; d.set_psr = 1'b1; end
            OP_CMPI: begin d.alu = ALU_CMP; d.set_psr = 1'b1; d.wb = 1'b0; end
            OP_ANDI: begin d.alu = ALU_AND; d.zext = 1'b1; end
            OP_ORI:  begin d.alu = ALU_OR;  d.zext = 1'b1; end
            OP_XORI: begin d.alu = ALU_XOR; d.zext = 1'b1; end
            OP_MOVI: begin d.alu = ALU_MOV; d.mov = 1'b1; end
            default: d = '0;
        endcase
        return d;
    endfunction

    // Anything not recognised decodes to valid=0, which EXEC treats as a NOP.
    function automatic exec_dec_t decode_exec(input logic [OP_W-1:0] op,
                                              input logic [OP_W-1:0] ext);
        exec_dec_t d;
        d = '0;
        if (op == OP_RTYPE) begin
            d      = alu_op(ext);
            d.zext = 1'b0;
        end else if (op == OP_SHIFT) begin
            if (ext == EXT_LSH || ext[3:1] == 3'b000) begin
                d.valid     = 1'b1;
                d.wb        = 1'b1;
                d.shift     = 1'b1;
                d.shift_imm = (ext != EXT_LSH);
                d.alu       = ALU_ADD;
            end
        end else begin
            d     = alu_op(op);
            d.imm = d.valid;
        end
        return d;
    endfunction

endpackage

// File: rtl/branchCond.sv
// Combinational branch resolution: condition code against captured {C,L,F,Z,N}.
module branchCond
    import ctrl_pkg::*;
(
    input  logic [3:0]       i_cond,
    input  logic [PSR_W-1:0] i_psr,
    output logic             o_taken_c
);

    logic w_c, w_l, w_f, w_z, w_n;
    assign {w_c, w_l, w_f, w_z, w_n} = i_psr;

    always_comb begin
        o_taken_c = 1'b0;
        case (i_cond)
            COND_EQ: o_taken_c = w_z;
            COND_NE: o_taken_c = !w_z;
            COND_CS: o_taken_c = w_c;
            COND_CC: o_taken_c = !w_c;
            COND_HI: o_taken_c = w_l;
            COND_LS: o_taken_c = !w_l;
            COND_GT: o_taken_c = w_n;
            COND_LE: o_taken_c = !w_n;
            COND_FS: o_taken_c = w_f;
            COND_FC: o_taken_c = !w_f;
            COND_LO: o_taken_c = !w_l && !w_z;
            COND_HS: o_taken_c = w_l || w_z;
            COND_LT: o_taken_c = !w_n && !w_z;
            COND_GE: o_taken_c = w_n || w_z;
            COND_UC: o_taken_c = 1'b1;
            COND_NV: o_taken_c = 1'b0;
            default: o_taken_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle control FSM for the 16-bit datapath: owns PC, PSR and the
// instruction register, and drives every datapath enable/select from state.
module datapath_controller
    import ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] instruction,
    input  logic              memReady,
    input  logic              C,
    input  logic              L,
    input  logic              F,
    input  logic              Z,
    input  logic              N,
    output logic [DATA_W-1:0] pc,
    output logic              adrSel,
    output logic              memWe,
    output logic              irS,
    output logic              srcRegEn,
    output logic              dstRegEn,
    output logic              immRegEn,
    output logic              regFileEn,
    output logic              signEn,
    output logic [1:0]        mux4En,
    output logic [1:0]        exMemResultEn,
    output logic              regImmMuxEn,
    output logic              shiftALUMuxEn,
    output logic [ALU_W-1:0]  aluControl,
    output logic [PSR_W-1:0]  psr
);

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    logic [PSR_W-1:0]  r_psr;
    logic [DATA_W-1:0] w_pc_next;
    logic              w_pc_en;
    logic              w_psr_en;
    logic              w_taken;
    exec_dec_t         w_dec;

    logic [OP_W-1:0] w_op;
    logic [OP_W-1:0] w_cond;
    logic [OP_W-1:0] w_ext;
    logic [7:0]      w_imm;

    assign w_op   = r_ir[15:12];
    assign w_cond = r_ir[11:8];
    assign w_ext  = r_ir[7:4];
    assign w_imm  = r_ir[7:0];
    assign w_dec  = decode_exec(w_op, w_ext);
    assign pc     = r_pc;
    assign psr    = r_psr;

    branchCond u_branch_cond (
        .i_cond    (w_cond),
        .i_psr     (r_psr),
        .o_taken_c (w_taken)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_psr   <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_pc_en)  r_pc  <= w_pc_next;
            if (w_psr_en) r_psr <= {C, L, F, Z, N};
            if (irS)      r_ir  <= instruction;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pc_en       = 1'b0;
        w_pc_next     = r_pc + 16'd1;
        w_psr_en      = 1'b0;
        adrSel        = 1'b0;
        memWe         = 1'b0;
        irS           = 1'b0;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        regFileEn     = 1'b0;
        signEn        = 1'b0;
        mux4En        = MUX4_REG;
        exMemResultEn = WB_ALU;
        regImmMuxEn   = 1'b0;
        shiftALUMuxEn = 1'b0;
        aluControl    = ALU_ADD;

        case (r_state)
            S_FETCH: begin
                if (memReady) begin
                    irS          = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                srcRegEn = 1'b1;
                dstRegEn = 1'b1;
                immRegEn = 1'b1;
                signEn   = w_dec.valid && !(w_dec.imm && w_dec.zext);
                if (w_op == OP_MEM && w_ext == EXT_LOAD)      w_state_next = S_LOAD_MEM;
                else if (w_op == OP_MEM && w_ext == EXT_STOR) w_state_next = S_STOR;
                else if (w_op == OP_BCOND)                    w_state_next = S_BRANCH;
                else                                          w_state_next = S_EXEC;
            end
            S_EXEC: begin
                regFileEn     = w_dec.valid && w_dec.wb;
                mux4En        = w_dec.imm ? MUX4_IMM : MUX4_REG;
                exMemResultEn = w_dec.mov ? WB_MOV : WB_ALU;
                shiftALUMuxEn = w_dec.shift;
                regImmMuxEn   = w_dec.shift_imm;
                signEn        = w_dec.valid && !(w_dec.imm && w_dec.zext);
                aluControl    = w_dec.alu;
                w_psr_en      = w_dec.valid && w_dec.set_psr;
                w_pc_en       = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_LOAD_MEM: begin
                adrSel = 1'b1;
                if (memReady) w_state_next = S_LOAD_WB;
            end
            S_LOAD_WB: begin
                exMemResultEn = WB_MEM;
                regFileEn     = 1'b1;
                w_pc_en       = 1'b1;
                w_state_next  = S_FETCH;
            end
            S_STOR: begin
                adrSel       = 1'b1;
                memWe        = 1'b1;
                w_pc_en      = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                // Displacement is the low byte, sign-extended; wraps mod 2^16.
                if (w_taken) w_pc_next = r_pc + {{8{w_imm[7]}}, w_imm};
                w_pc_en      = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench for datapath_controller: table of single-instruction vectors
// plus hand-written LOAD stall, STOR wrap and mid-instruction reset sequences.
module tb_datapath_controller;

    logic        clk;
    logic        reset_n;
    logic [15:0] instruction;
    logic        memReady;
    logic        C, L, F, Z, N;
    logic [15:0] pc;
    logic        adrSel, memWe, irS, srcRegEn, dstRegEn, immRegEn, regFileEn, signEn;
    logic [1:0]  mux4En, exMemResultEn;
    logic        regImmMuxEn, shiftALUMuxEn;
    logic [3:0]  aluControl;
    logic [4:0]  psr;

    int checks = 0;
    int errors = 0;

    datapath_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .instruction   (instruction),
        .memReady      (memReady),
        .C             (C),
        .L             (L),
        .F             (F),
        .Z             (Z),
        .N             (N),
        .pc            (pc),
        .adrSel        (adrSel),
        .memWe         (memWe),
        .irS           (irS),
        .srcRegEn      (srcRegEn),
        .dstRegEn      (dstRegEn),
        .immRegEn      (immRegEn),
        .regFileEn     (regFileEn),
        .signEn        (signEn),
        .mux4En        (mux4En),
        .exMemResultEn (exMemResultEn),
        .regImmMuxEn   (regImmMuxEn),
        .shiftALUMuxEn (shiftALUMuxEn),
        .aluControl    (aluControl),
        .psr           (psr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [4:0]  flags;
        logic [13:0] ctl;
        logic [15:0] pc;
        logic [4:0]  psr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // {regFileEn, memWe, adrSel, mux4En, exMemResultEn, aluControl, signEn, shiftALUMuxEn, regImmMuxEn}
    function automatic logic [13:0] ctl_word(input logic rf, input logic we, input logic adr,
                                             input logic [1:0] mx, input logic [1:0] exm,
                                             input logic [3:0] alu, input logic sg,
                                             input logic sh, input logic ri);
        return {rf, we, adr, mx, exm, alu, sg, sh, ri};
    endfunction

    function automatic logic [13:0] ctl_act();
        return {regFileEn, memWe, adrSel, mux4En, exMemResultEn, aluControl,
                signEn, shiftALUMuxEn, regImmMuxEn};
    endfunction

    task automatic add(input string n, input logic [15:0] ins, input logic [4:0] fl,
                       input logic [13:0] c, input logic [15:0] p, input logic [4:0] ps);
        vec_t v;
        v.name = n; v.instr = ins; v.flags = fl; v.ctl = c; v.pc = p; v.psr = ps;
        vq.push_back(v);
    endtask

    // Entered and left at negedge+1 with the DUT in FETCH.
    task automatic run_vec(input vec_t v);
        instruction = v.instr;
        {C, L, F, Z, N} = v.flags;
        memReady = 1'b1;
        #1;
        check({v.name, ":irS"}, 32'(irS), 32'd1);
        @(negedge clk); #1;
        check({v.name, ":dec"}, 32'({srcRegEn, dstRegEn, immRegEn, irS, regFileEn, memWe}), 32'b111000);
        @(negedge clk); #1;
        check({v.name, ":ctl"}, 32'(ctl_act()), 32'(v.ctl));
        @(negedge clk); #1;
        check({v.name, ":pc"}, 32'(pc), 32'(v.pc));
        check({v.name, ":psr"}, 32'(psr), 32'(v.psr));
    endtask

    localparam logic [13:0] CTL_IDLE = 14'd0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt;
        vec_t v;

        add("add",   16'h0152, 5'b10010, ctl_word(1'b1,1'b0,1'b0,2'b00,2'b00,4'h0,1'b1,1'b0,1'b0), 16'h0001, 5'b10010);
        add("cmpi",  16'hB305, 5'b00010, ctl_word(1'b0,1'b0,1'b0,2'b01,2'b00,4'h2,1'b1,1'b0,1'b0), 16'h0002, 5'b00010);
        add("beq_t", 16'hC0FD, 5'b11111, CTL_IDLE, 16'hFFFF, 5'b00010);
        add("bne_n", 16'hC1FD, 5'b11111, CTL_IDLE, 16'h0000, 5'b00010);
        add("andi",  16'h1280, 5'b11111, ctl_word(1'b1,1'b0,1'b0,2'b01,2'b00,4'h3,1'b0,1'b0,1'b0), 16'h0001, 5'b00010);
        add("mov",   16'h04D5, 5'b11111, ctl_word(1'b1,1'b0,1'b0,2'b00,2'b10,4'h6,1'b1,1'b0,1'b0), 16'h0002, 5'b00010);
        add("movi",  16'hD407, 5'b11111, ctl_word(1'b1,1'b0,1'b0,2'b01,2'b10,4'h6,1'b1,1'b0,1'b0), 16'h0003, 5'b00010);
        add("lshi",  16'h8101, 5'b11111, ctl_word(1'b1,1'b0,1'b0,2'b00,2'b00,4'h0,1'b1,1'b1,1'b1), 16'h0004, 5'b00010);
        add("lsh",   16'h8142, 5'b11111, ctl_word(1'b1,1'b0,1'b0,2'b00,2'b00,4'h0,1'b1,1'b1,1'b0), 16'h0005, 5'b00010);
        add("sub",   16'h0192, 5'b01001, ctl_word(1'b1,1'b0,1'b0,2'b00,2'b00,4'h1,1'b1,1'b0,1'b0), 16'h0006, 5'b01001);
        add("bhi_t", 16'hC405, 5'b00000, CTL_IDLE, 16'h000B, 5'b01001);
        add("bgt_t", 16'hC610, 5'b00000, CTL_IDLE, 16'h001B, 5'b01001);
        add("ble_n", 16'hC7F0, 5'b00000, CTL_IDLE, 16'h001C, 5'b01001);
        add("cmp",   16'h01B2, 5'b00000, ctl_word(1'b0,1'b0,1'b0,2'b00,2'b00,4'h2,1'b1,1'b0,1'b0), 16'h001D, 5'b00000);
        add("beq_n", 16'hC0FD, 5'b11111, CTL_IDLE, 16'h001E, 5'b00000);
        add("blo_t", 16'hCA02, 5'b11111, CTL_IDLE, 16'h0020, 5'b00000);
        add("buc_t", 16'hCE80, 5'b11111, CTL_IDLE, 16'hFFA0, 5'b00000);
        add("bnv_n", 16'hCF05, 5'b11111, CTL_IDLE, 16'hFFA1, 5'b00000);
        add("nop",   16'hF000, 5'b11111, CTL_IDLE, 16'hFFA2, 5'b00000);

        // Reset state
        reset_n = 1'b0; memReady = 1'b0; instruction = 16'h0000; {C, L, F, Z, N} = 5'b11111;
        repeat (2) @(negedge clk);
        #1;
        check("rst:pc",  32'(pc),  32'h0);
        check("rst:psr", 32'(psr), 32'h0);
        check("rst:ctl", 32'(ctl_act()), 32'h0);
        check("rst:dec", 32'({irS, srcRegEn, dstRegEn, immRegEn}), 32'h0);
        reset_n = 1'b1;

        // FETCH holds while memReady is low
        repeat (2) begin
            @(negedge clk); #1;
            check("stall:irS_pc", 32'({irS, pc}), 32'h0);
        end

        foreach (vq[i]) run_vec(vq[i]);

        // LOAD with memReady low for three LOAD_MEM cycles
        instruction = 16'h4102; {C, L, F, Z, N} = 5'b11111; memReady = 1'b1;
        @(negedge clk); #1;
        memReady = 1'b0;
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) memReady = 1'b1;
            check("ld:mem_adr", 32'({adrSel, regFileEn, exMemResultEn}), 32'b1000);
            @(negedge clk); #1;
        end
        check("ld:wb", 32'({adrSel, regFileEn, exMemResultEn}), 32'b0101);
        check("ld:wb_pc", 32'(pc), 32'hFFA2);
        @(negedge clk); #1;
        check("ld:done", 32'({regFileEn, pc}), 32'h0FFA3);
        check("ld:psr", 32'(psr), 32'h0);

        // Branch to 0xFFFF, then STOR there
        v.name = "buc_ff"; v.instr = 16'hCE5C; v.flags = 5'b11111; v.ctl = CTL_IDLE;
        v.pc = 16'hFFFF; v.psr = 5'b00000;
        run_vec(v);
        instruction = 16'h4142; memReady = 1'b1; we_cnt = 0;
        #1;
        if (memWe) we_cnt++;
        @(negedge clk); #1;
        if (memWe) we_cnt++;
        @(negedge clk); #1;
        check("st:adr", 32'({adrSel, regFileEn}), 32'b10);
        if (memWe) we_cnt++;
        @(negedge clk); #1;
        if (memWe) we_cnt++;
        check("st:we_cnt", 32'(we_cnt), 32'd1);
        check("st:pc_wrap", 32'(pc), 32'h0000);

        // Reset in LOAD_WB
        v.name = "add2"; v.instr = 16'h0152; v.flags = 5'b10101;
        v.ctl = ctl_word(1'b1,1'b0,1'b0,2'b00,2'b00,4'h0,1'b1,1'b0,1'b0);
        v.pc = 16'h0001; v.psr = 5'b10101;
        run_vec(v);
        instruction = 16'h4102; memReady = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rstwb:pre", 32'({regFileEn, exMemResultEn}), 32'b101);
        #1 reset_n = 1'b0;
        #1;
        check("rstwb:rf", 32'({regFileEn, exMemResultEn, adrSel, memWe}), 32'h0);
        check("rstwb:pc", 32'(pc), 32'h0);
        check("rstwb:psr", 32'(psr), 32'h0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        check("rstwb:fetch", 32'({irS, pc}), 32'h10000);
        @(negedge clk); #1;
        check("rstwb:decode", 32'({srcRegEn, pc}), 32'h10000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
